uart_link_arbiter: RTL

Round-robin arbiter and packet sequencer that shares the single `uart_tx` byte stream of the Basys3 UART link among `NUM_REQ` on-chip requesters. Each granted requester sends one framed packet: header, length, payload and XOR checksum. The grant is held for the whole packet. The block sits between the requester logic and the `uart_tx` byte-level handshake.

---
 rtl/uart_link_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_link_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART link arbiter.
//   arb_state_t : packet sequencer states
//   HDR_SYNC    : sync nibble placed in the upper half of every header byte
//   make_header : builds the header byte from a requester id
package uart_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } arb_state_t;

    localparam logic [3:0] HDR_SYNC = 4'hA;

    function automatic logic [7:0] make_header(input logic [3:0] id);
        return {HDR_SYNC, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority select.
//   rr_ptr    in  : index with highest priority this round
//   req       in  : request vector
//   gnt_idx   out : first set request at or above rr_ptr, wrapping
//   gnt_valid out : at least one request is set
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int LB_NUM_REQ = $clog2(NUM_REQ)
) (
    input  logic [LB_NUM_REQ-1:0] rr_ptr,
    input  logic [NUM_REQ-1:0]    req,
    output logic [LB_NUM_REQ-1:0] gnt_idx,
    output logic                  gnt_valid
);

    int idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!gnt_valid && req[LB_NUM_REQ'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = LB_NUM_REQ'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_link_arbiter.sv
// Shares one uart_tx byte stream among NUM_REQ requesters. Each grant sends
// one framed packet: header {A, id}, length, payload, XOR checksum.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for any req_valid; arbitrate and latch length
// HDR     | header byte presented (registered)
// LEN     | length byte presented (registered)
// DATA    | grantee's payload passed straight through to uart_tx
// CSUM    | checksum byte presented (registered); advance rr pointer
//
// Ports:
//   clk, reset (async, active high), ena (freezes all state when low)
//   req_valid/req_len/req_data : per-requester packet request and payload
//   req_ready                  : payload byte of the grantee consumed
//   tx_data/tx_valid/tx_ready  : byte handshake to uart_tx
//   busy                       : packet in progress
//   grant_id                   : current or most recent grantee
module uart_link_arbiter
    import uart_link_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 16,
    localparam int LB_NUM_REQ = $clog2(NUM_REQ),
    localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [LB_NUM_REQ-1:0]         grant_id
);

    arb_state_t              state_q, state_d;
    logic [LB_NUM_REQ-1:0]   grant_q, grant_d;
    logic [LB_NUM_REQ-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   csum_q, csum_d;
    logic                    txv_q, txv_d;
    logic [DATA_WIDTH-1:0]   txd_q, txd_d;

    logic [LB_NUM_REQ-1:0]   arb_idx;
    logic                    arb_valid;
    logic [LEN_W-1:0]        len_raw;
    logic [LEN_W-1:0]        len_clamp;
    logic [DATA_WIDTH-1:0]   data_sel;
    logic                    valid_sel;
    logic                    in_data;
    logic                    xfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .rr_ptr    (rr_ptr_q),
        .req       (req_valid),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        len_raw   = req_len[int'(arb_idx)*LEN_W +: LEN_W];
        len_clamp = (len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_raw;
        data_sel  = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        valid_sel = req_valid[grant_q];
        in_data   = (state_q == ST_DATA);
        // Payload bytes bypass the output register so the requester's own
        // valid/data reach uart_tx in the same cycle.
        tx_valid  = in_data ? valid_sel : txv_q;
        tx_data   = in_data ? data_sel : txd_q;
        xfer      = tx_valid && tx_ready && ena;
        req_ready = '0;
        if (in_data && xfer) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        txv_d    = txv_q;
        txd_d    = txd_q;
        case (state_q)
            ST_IDLE: begin
                if (ena && arb_valid) begin
                    grant_d = arb_idx;
                    len_d   = len_clamp;
                    cnt_d   = len_clamp;
                    csum_d  = '0;
                    txd_d   = make_header(4'(arb_idx));
                    txv_d   = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    txd_d   = DATA_WIDTH'(len_q);
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if (len_q == '0) begin
                        txd_d   = csum_q;
                        state_d = ST_CSUM;
                    end else begin
                        txv_d   = 1'b0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ data_sel;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        txd_d   = csum_q ^ data_sel;
                        txv_d   = 1'b1;
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    txv_d    = 1'b0;
                    rr_ptr_d = (grant_q == LB_NUM_REQ'(NUM_REQ - 1)) ?
                               '0 : grant_q + LB_NUM_REQ'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            csum_q   <= '0;
            txv_q    <= 1'b0;
            txd_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            txv_q    <= txv_d;
            txd_q    <= txd_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

endmodule
